// File: rtl/bj_mem_client.sv
// Blackjack game-state RAM command sequencer.
// Takes one high-level game command at a time and expands it into
// read / capture / write sequences on a 32x8 RAM with a 1-cycle read.
// All outputs are registered and are set on the edge that enters a state.
module bj_mem_client #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_CARDS  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr_wr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we
);

  typedef enum logic [3:0] {IDLE, RD1, CAP1, RD2, CAP2, WR1, WR2, WR3, FIN} state_t;

  localparam logic [2:0] OP_ADD_P = 3'd1, OP_ADD_D = 3'd2, OP_BET   = 3'd3,
                         OP_WIN   = 3'd4, OP_PUSH  = 3'd5, OP_LOSE  = 3'd6,
                         OP_STATE = 3'd7;

  localparam logic [ADDR_WIDTH-1:0] A_PBASE = 5'h00, A_PCNT = 5'h0B,
                                    A_DBASE = 5'h0C, A_DCNT = 5'h17,
                                    A_STATE = 5'h18, A_BET  = 5'h19,
                                    A_BAL   = 5'h1A, A_PSCR = 5'h1B,
                                    A_DSCR  = 5'h1C,
                                    // unused location: read port parks here
                                    // while writes are in flight
                                    A_PARK  = 5'h1F;

  localparam logic [DATA_WIDTH-1:0] SAT = '1;

  state_t                state;
  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] r1;

  logic                  is_dealer;
  logic [ADDR_WIDTH-1:0] base_a, cnt_a, scr_a, slot_a;
  logic                  card_ok;
  logic [DATA_WIDTH-1:0] card_val, card_sum, settle_sum;
  logic [DATA_WIDTH:0]   card_sum9;
  logic [DATA_WIDTH+1:0] settle_sum10;

  // Per-command address selection, card value and saturating sums
  always_comb begin
    is_dealer = (op_q == OP_ADD_D);
    base_a    = is_dealer ? A_DBASE : A_PBASE;
    cnt_a     = is_dealer ? A_DCNT  : A_PCNT;
    scr_a     = is_dealer ? A_DSCR  : A_PSCR;
    slot_a    = base_a + mem_rdata[ADDR_WIDTH-1:0];
    card_ok   = (data_q != '0) && (data_q <= DATA_WIDTH'(13));
    card_val  = (data_q > DATA_WIDTH'(10)) ? DATA_WIDTH'(10) : data_q;
    card_sum9 = {1'b0, mem_rdata} + {1'b0, card_val};
    card_sum  = card_sum9[DATA_WIDTH] ? SAT : card_sum9[DATA_WIDTH-1:0];
    settle_sum10 = {2'b00, mem_rdata} +
                   ((op_q == OP_WIN) ? {1'b0, r1, 1'b0} : {2'b00, r1});
    settle_sum = (settle_sum10 > {2'b00, SAT}) ? SAT : settle_sum10[DATA_WIDTH-1:0];
  end

  // Command FSM; outputs for a state are loaded on the edge entering it
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr_rd <= '0;
      mem_addr_wr <= '0;
      mem_wdata   <= '0;
      op_q        <= '0;
      data_q      <= '0;
      r1          <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            data_q    <= cmd_data;
            case (cmd_op)
              OP_ADD_P: begin state <= RD1; mem_addr_rd <= A_PCNT; end
              OP_ADD_D: begin state <= RD1; mem_addr_rd <= A_DCNT; end
              OP_BET:   begin state <= RD1; mem_addr_rd <= A_BAL;  end
              OP_WIN, OP_PUSH: begin state <= RD1; mem_addr_rd <= A_BET; end
              OP_LOSE: begin
                state <= WR2; mem_we <= 1'b1; mem_addr_wr <= A_BET; mem_wdata <= '0;
              end
              OP_STATE: begin
                if (cmd_data > DATA_WIDTH'(4)) begin
                  state <= FIN; done <= 1'b1; err <= 1'b1;
                end else begin
                  state <= WR1; mem_we <= 1'b1; mem_addr_wr <= A_STATE; mem_wdata <= cmd_data;
                end
              end
              default: begin state <= FIN; done <= 1'b1; err <= 1'b1; end
            endcase
          end
        end
        RD1: state <= CAP1;
        CAP1: begin
          r1          <= mem_rdata;
          mem_addr_rd <= A_PARK;
          case (op_q)
            OP_ADD_P, OP_ADD_D: begin
              if (!card_ok || mem_rdata >= DATA_WIDTH'(MAX_CARDS)) begin
                state <= FIN; done <= 1'b1; err <= 1'b1;
              end else begin
                state <= WR1; mem_we <= 1'b1; mem_addr_wr <= slot_a; mem_wdata <= data_q;
              end
            end
            OP_BET: begin
              if (data_q == '0 || data_q > mem_rdata) begin
                state <= FIN; done <= 1'b1; err <= 1'b1;
              end else begin
                state <= WR1; mem_we <= 1'b1; mem_addr_wr <= A_BAL; mem_wdata <= mem_rdata - data_q;
              end
            end
            default: begin state <= RD2; mem_addr_rd <= A_BAL; end
          endcase
        end
        RD2: state <= CAP2;
        CAP2: begin
          mem_addr_rd <= A_PARK;
          mem_we      <= 1'b1;
          if (op_q == OP_ADD_P || op_q == OP_ADD_D) begin
            state <= WR3; mem_addr_wr <= scr_a; mem_wdata <= card_sum;
          end else begin
            state <= WR1; mem_addr_wr <= A_BAL; mem_wdata <= settle_sum;
          end
        end
        WR1: begin
          if (op_q == OP_STATE) begin
            state <= FIN; done <= 1'b1;
          end else begin
            state  <= WR2;
            mem_we <= 1'b1;
            case (op_q)
              OP_ADD_P, OP_ADD_D: begin mem_addr_wr <= cnt_a; mem_wdata <= r1 + 1'b1; end
              OP_BET:             begin mem_addr_wr <= A_BET; mem_wdata <= data_q; end
              default:            begin mem_addr_wr <= A_BET; mem_wdata <= '0; end
            endcase
          end
        end
        WR2: begin
          if (op_q == OP_ADD_P || op_q == OP_ADD_D) begin
            state <= RD2; mem_addr_rd <= scr_a;
          end else begin
            state <= FIN; done <= 1'b1;
          end
        end
        WR3: begin state <= FIN; done <= 1'b1; end
        FIN: begin state <= IDLE; cmd_ready <= 1'b1; end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
